// File: rtl/axis_mux_arbiter_if.sv
// AXI-Stream style handshake bundle shared by the requester and output sides
// of axis_mux_arbiter.
interface axis_mux_arbiter_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_mux_arbiter.sv
// Two-input packet-locked round-robin stream mux.
// Define AXIS_MUX_OUT_REG_EN to place a 2-entry skid register on the output.
module axis_mux_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                 counter_clk,
    input  logic                 reset,
    axis_mux_arbiter_if.slave    s0,
    axis_mux_arbiter_if.slave    s1,
    axis_mux_arbiter_if.master   m,
    output logic                 m_tsel,
    output logic                 busy
);
    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              mid_q, mid_d;
    logic              tsel_q, tsel_d;

    logic              granted, gsel;
    logic              sel_valid, sel_last, int_ready, accept;
    logic [DATA_W-1:0] sel_data;
    logic              own_valid, other_valid;
    state_e            own_st, other_st;

    always_comb begin
        granted     = (state_q != StIdle);
        gsel        = (state_q == StGrant1);
        own_valid   = gsel ? s1.tvalid : s0.tvalid;
        other_valid = gsel ? s0.tvalid : s1.tvalid;
        own_st      = gsel ? StGrant1 : StGrant0;
        other_st    = gsel ? StGrant0 : StGrant1;
        sel_valid   = granted & own_valid;
        sel_last    = granted & (gsel ? s1.tlast : s0.tlast);
        sel_data    = granted ? (gsel ? s1.tdata : s0.tdata) : '0;
        accept      = sel_valid & int_ready;
        s0.tready   = (state_q == StGrant0) & int_ready;
        s1.tready   = (state_q == StGrant1) & int_ready;
        busy        = granted;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mid_d        = mid_q;
        unique case (state_q)
            StIdle: begin
                if (s0.tvalid && s1.tvalid) begin
                    state_d = last_grant_q ? StGrant0 : StGrant1;
                end else if (s0.tvalid) begin
                    state_d = StGrant0;
                end else if (s1.tvalid) begin
                    state_d = StGrant1;
                end
            end
            StGrant0, StGrant1: begin
                if (accept && sel_last) begin
                    last_grant_d = gsel;
                    mid_d        = 1'b0;
                    state_d      = other_valid ? other_st : (own_valid ? own_st : StIdle);
                end else if (accept) begin
                    mid_d = 1'b1;
                end else if (!mid_q && !own_valid) begin
                    // Between packets with the owner gone quiet: release the grant.
                    state_d = other_valid ? other_st : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge counter_clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            mid_q        <= 1'b0;
            tsel_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mid_q        <= mid_d;
            tsel_q       <= tsel_d;
        end
    end

`ifdef AXIS_MUX_OUT_REG_EN
    // Each slot holds {tsel, tlast, tdata}.
    logic [DATA_W+1:0] slot_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;
    logic              pop;
    logic [DATA_W+1:0] head;

    always_comb begin
        head      = slot_q[rd_ptr_q];
        int_ready = (count_q != 2'd2);
        m.tvalid  = (count_q != 2'd0);
        pop       = m.tvalid & m.tready;
        m.tdata   = m.tvalid ? head[DATA_W-1:0] : '0;
        m.tlast   = m.tvalid & head[DATA_W];
        m_tsel    = m.tvalid ? head[DATA_W+1] : tsel_q;
        tsel_d    = pop ? head[DATA_W+1] : tsel_q;
    end

    always_ff @(posedge counter_clk) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (accept) begin
                slot_q[wr_ptr_q] <= {gsel, sel_last, sel_data};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, accept} - {1'b0, pop};
        end
    end
`else
    always_comb begin
        int_ready = m.tready;
        m.tvalid  = sel_valid;
        m.tdata   = sel_data;
        m.tlast   = sel_last;
        m_tsel    = granted ? gsel : tsel_q;
        tsel_d    = m_tsel;
    end
`endif

endmodule

// File: tb/tb_axis_mux_arbiter.sv
// Scoreboard bench for axis_mux_arbiter: expected beats are queued in the
// arbitration order the mux must produce and checked as they leave m.
module tb_axis_mux_arbiter;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              sel;
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m_tsel, busy;

    always #5 clk = ~clk;

    axis_mux_arbiter_if #(.DATA_W(DATA_W)) s0_if ();
    axis_mux_arbiter_if #(.DATA_W(DATA_W)) s1_if ();
    axis_mux_arbiter_if #(.DATA_W(DATA_W)) m_if ();

    axis_mux_arbiter #(.DATA_W(DATA_W)) dut (
        .counter_clk (clk),
        .reset       (rst_n),
        .s0          (s0_if),
        .s1          (s1_if),
        .m           (m_if),
        .m_tsel      (m_tsel),
        .busy        (busy)
    );

    beat_t exp_q[$];
    beat_t mon_exp;
    beat_t mon_got;
    int    vectors = 0;
    int    errors = 0;
    bit    mon_en = 1'b1;
    int    cyc = 0;
    int    last_beat_cyc = -1;
    int    max_gap = 0;
    int    s1_rdy_seen = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (s1_if.tready) s1_rdy_seen++;
        if (rst_n && m_if.tvalid && m_if.tready) begin
            if (last_beat_cyc >= 0 && (cyc - last_beat_cyc) > max_gap)
                max_gap = cyc - last_beat_cyc;
            last_beat_cyc = cyc;
            if (mon_en) begin
                vectors++;
                mon_got = {m_tsel, m_if.tlast, m_if.tdata};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got sel=%0d last=%0d data=%0h, required no beat",
                             m_tsel, m_if.tlast, m_if.tdata);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL beat: got sel=%0d last=%0d data=%0h, required sel=%0d last=%0d data=%0h",
                                 mon_got.sel, mon_got.last, mon_got.data,
                                 mon_exp.sel, mon_exp.last, mon_exp.data);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic drive(input bit src, input logic v, input logic [DATA_W-1:0] d, input logic l);
        if (src) begin
            s1_if.tvalid = v; s1_if.tdata = d; s1_if.tlast = l;
        end else begin
            s0_if.tvalid = v; s0_if.tdata = d; s0_if.tlast = l;
        end
    endtask

    // Send nbeats consecutive values from base, tlast every pkt_len beats.
    task automatic send(input bit src, input int base, input int nbeats, input int pkt_len);
        bit acc;
        int waits;
        for (int i = 0; i < nbeats; i++) begin
            @(posedge clk); #1;
            drive(src, 1'b1, DATA_W'(base + i), (i % pkt_len) == pkt_len - 1);
            waits = 0;
            acc = 1'b0;
            while (!acc && waits < 200) begin
                @(negedge clk);
                acc = src ? s1_if.tready : s0_if.tready;
                waits++;
            end
            if (!acc) begin
                vectors++; errors++;
                $display("FAIL handshake_timeout: src=%0d beat=%0d not accepted, required accept", src, i);
            end
        end
        @(posedge clk); #1;
        drive(src, 1'b0, '0, 1'b0);
    endtask

    task automatic push(input bit sel, input bit last, input int data);
        beat_t b;
        b.sel = sel; b.last = last; b.data = DATA_W'(data);
        exp_q.push_back(b);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_gap(input string name);
        vectors++;
        if (max_gap !== 1) begin
            errors++;
            $display("FAIL %s_gap: max cycles between beats %0d, required 1", name, max_gap);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        last_beat_cyc = -1;
        max_gap = 0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 32'hdead, 1'b1);
        drive(1'b1, 1'b1, 32'hbeef, 1'b1);
        @(posedge clk);
        @(negedge clk);
        got = {m_if.tvalid, m_if.tlast, m_tsel, busy, s0_if.tready, s1_if.tready};
        vectors++;
        if (got !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: {tvalid,tlast,tsel,busy,rdy0,rdy1}=%b, required 000000", got);
        end
        vectors++;
        if (m_if.tdata !== '0) begin
            errors++;
            $display("FAIL reset_data: m_tdata=%0h, required 0", m_if.tdata);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_single_source();
        do_reset();
        for (int i = 0; i < 20; i++) push(1'b0, i == 19, i);
        s1_rdy_seen = 0;
        fork
            send(1'b0, 0, 20, 20);
            begin
                repeat (10) @(negedge clk);
                vectors++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_mid_packet: busy=%0d, required 1", busy);
                end
            end
        join
        wait_drain();
        check_gap("single_source");
        vectors++;
        if (s1_rdy_seen !== 0) begin
            errors++;
            $display("FAIL s1_tready_idle: high for %0d cycles, required 0", s1_rdy_seen);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_packet: busy=%0d, required 0", busy);
        end
    endtask

    task automatic test_tie();
        do_reset();
        for (int i = 0; i < 4; i++) push(1'b0, i == 3, 'h100 + i);
        for (int i = 0; i < 4; i++) push(1'b1, i == 3, 'h200 + i);
        fork
            send(1'b0, 'h100, 4, 4);
            send(1'b1, 'h200, 4, 4);
        join
        wait_drain();
        check_gap("tie");
        vectors++;
        if (m_tsel !== 1'b1) begin
            errors++;
            $display("FAIL tsel_hold_idle: m_tsel=%0d, required 1", m_tsel);
        end
    endtask

    task automatic test_late_request();
        do_reset();
        for (int i = 0; i < 8; i++) push(1'b0, i == 7, 'h300 + i);
        for (int i = 0; i < 4; i++) push(1'b1, i == 3, 'h400 + i);
        fork
            send(1'b0, 'h300, 8, 8);
            begin
                repeat (3) @(posedge clk);
                send(1'b1, 'h400, 4, 4);
            end
        join
        wait_drain();
        check_gap("late_request");
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 10; i++) push(1'b0, i == 9, 'h500 + i);
        fork
            send(1'b0, 'h500, 10, 10);
            begin
                repeat (5) @(posedge clk); #1;
                m_if.tready = 1'b0;
                repeat (10) @(negedge clk);
                vectors++;
                if (m_if.tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_valid: m_tvalid=%0d, required 1", m_if.tvalid);
                end
                repeat (10) @(posedge clk); #1;
                m_if.tready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_reset_mid_packet();
        logic [5:0] got;
        int waits;
        do_reset();
        mon_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b1, DATA_W'('h600 + i), 1'b0);
            waits = 0;
            do begin
                @(negedge clk);
                waits++;
            end while (!s0_if.tready && waits < 50);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        got = {m_if.tvalid, m_if.tlast, m_tsel, busy, s0_if.tready, s1_if.tready};
        vectors++;
        if (got !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: {tvalid,tlast,tsel,busy,rdy0,rdy1}=%b, required 000000", got);
        end
        vectors++;
        if (m_if.tdata !== '0) begin
            errors++;
            $display("FAIL mid_reset_data: m_tdata=%0h, required 0", m_if.tdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        push(1'b0, 1'b1, 'h700);
        push(1'b1, 1'b1, 'h701);
        fork
            send(1'b0, 'h700, 1, 1);
            send(1'b1, 'h701, 1, 1);
        join
        wait_drain();
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 12; i++)
            push(1'(i % 2), 1'b1, (i % 2) ? ('h900 + i / 2) : ('h800 + i / 2));
        fork
            send(1'b0, 'h800, 6, 1);
            send(1'b1, 'h900, 6, 1);
        join
        wait_drain();
        check_gap("alternate");
    endtask

    initial begin
        s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tlast = 1'b0;
        s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0;
        m_if.tready = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_single_source();
        test_tie();
        test_late_request();
        test_stall();
        test_reset_mid_packet();
        test_alternate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/axis_mux_arbiter.md
AXIS_MUX_ARBITER -- requirements
Module: axis_mux_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of tdata on all streams.
REQ-002 SHALL have port counter_clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have ports s0_tdata in DATA_W, s0_tvalid in 1, s0_tready out 1, s0_tlast in 1: requester 0 stream.
REQ-005 SHALL have ports s1_tdata in DATA_W, s1_tvalid in 1, s1_tready out 1, s1_tlast in 1: requester 1 stream.
REQ-006 SHALL have ports m_tdata out DATA_W, m_tvalid out 1, m_tready in 1, m_tlast out 1: shared output stream.
REQ-007 SHALL have port m_tsel  output  1  source index of the current m_* beat.
REQ-008 SHALL have port busy  output  1  high while in a GRANT state.

Function
REQ-009 SHALL implement FSM states IDLE, GRANT0, GRANT1, plus a 1-bit last_grant register.
REQ-010 In IDLE with exactly one sx_tvalid high, SHALL go to GRANTx next cycle.
REQ-011 In IDLE with both tvalid high, SHALL grant the input not equal to last_grant.
REQ-012 In IDLE, SHALL hold s0_tready = s1_tready = 0 and accept no beat; arbitration latency from IDLE is 1 cycle.
REQ-013 In GRANTx, SHALL drive sx_tready = internal ready, route sx_tdata/tvalid/tlast to the output path, and hold the other tready at 0.
REQ-014 A beat SHALL transfer only on a cycle where valid and ready are both high on that interface.
REQ-015 Grant SHALL lock for the whole packet; switching before the tlast beat is accepted is forbidden.
REQ-016 On the cycle the tlast beat of sx is accepted, SHALL set last_grant = x and re-arbitrate in the same cycle: other input valid -> GRANT(other); else sx valid -> GRANTx; else IDLE. Back-to-back packets SHALL therefore have zero bubble cycles.
REQ-017 Deasserted sx_tvalid mid-packet SHALL hold the grant (no timeout); m_tvalid follows low.
REQ-018 A single-beat packet (tvalid and tlast together) SHALL be handled per REQ-016.
REQ-019 m_tsel SHALL equal the granted index in GRANTx; in IDLE it holds its last value.
REQ-020 Data, last and order SHALL be preserved exactly; no beat dropped or duplicated.

Reset
REQ-021 While reset = 0 at a clock edge: state = IDLE, last_grant = 1 (s0 wins first tie), s0_tready = s1_tready = 0, m_tvalid = 0, m_tlast = 0, m_tdata = 0, m_tsel = 0, busy = 0, output register slots empty.
REQ-022 Reset asserted mid-packet SHALL abort the packet; the remaining beats are not forwarded unless the source re-presents them after reset is released.
REQ-023 The first grant SHALL be possible on the first edge after reset returns to 1.

Configuration
REQ-024 Macro AXIS_MUX_OUT_REG_EN SHALL control the output register slice.
REQ-025 Without AXIS_MUX_OUT_REG_EN: m_tdata/m_tvalid/m_tlast SHALL be combinational from the granted input; internal ready = m_tready; latency 0.
REQ-026 With AXIS_MUX_OUT_REG_EN: m_* SHALL come from a 2-entry skid register; internal ready = skid not full; latency 1 cycle; full throughput (1 beat/cycle) with m_tready held high; no combinational path from m_tready to sx_tready.
REQ-027 With AXIS_MUX_OUT_REG_EN, m_tsel SHALL be registered with the beat it labels.

Verification
REQ-028 Only s0 sends a 20-beat packet (data 0..19, tlast on 19), m_tready = 1 -> m_tdata 0..19, m_tsel = 0, m_tlast on beat 19, s1_tready = 0 throughout.
REQ-029 Both valid from IDLE right after reset, 4-beat packets each -> s0 packet first, s1 packet next with zero-cycle gap, m_tsel 0,0,0,0,1,1,1,1.
REQ-030 s1 raises tvalid mid-way through an s0 packet -> no switch until s0 tlast is accepted; then GRANT1 in the same cycle.
REQ-031 m_tready low for 20 cycles mid-packet, then high -> stall with no beat loss or duplication, and data order intact (check both macro settings).
REQ-032 Reset = 0 for 1 cycle at beat 5 of a 10-beat s0 packet -> all outputs at reset values next cycle; state IDLE; s0 is granted first on the next tie.
REQ-033 Continuous single-beat packets on both inputs -> strict alternation 0,1,0,1 and 1 beat per cycle throughput.
